ela_deinterlacer: RTL

Parametrised deinterlacer. It reads a field-interlaced frame from the source BRAM (even rows valid, odd rows missing) and writes a full progressive frame to the processing memory. Four modes are supported: copy, field view, line average, and multi-channel edge-based line average (ELA). It sits between the image BRAM and the processing-memory write port and generalises the single-channel, fixed-size processor with an explicit start/done handshake.

---
 rtl/ela_deinterlacer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ela_deinterlacer.sv
// ela_deinterlacer: field-interlaced to progressive frame converter.
// Modes: copy, field view, line average, multi-channel ELA.
module ela_deinterlacer #(
  parameter int IMG_W      = 400,
  parameter int IMG_H      = 300,
  parameter int CH         = 3,
  parameter int CW         = 4,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [CH*CW-1:0]      rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [CH*CW-1:0]      wr_data
);

  localparam int DW  = CH * CW;
  localparam int DCW = CW + $clog2(CH + 1);
  localparam int RW  = $clog2(IMG_H);
  localparam int CLW = $clog2(IMG_W);
  localparam int AW  = ADDR_WIDTH;

  localparam logic [RW-1:0]  LAST_R = RW'(IMG_H - 1);
  localparam logic [CLW-1:0] LAST_C = CLW'(IMG_W - 1);
  localparam logic [CLW-1:0] PEN_C  = CLW'(IMG_W - 2);
  localparam logic [AW-1:0]  W_A    = AW'(IMG_W);
  localparam logic [AW-1:0]  ONE_A  = AW'(1);

  localparam logic [1:0] M_COPY  = 2'd0;
  localparam logic [1:0] M_FIELD = 2'd1;
  localparam logic [1:0] M_ELA   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROW_SEL,
    S_STREAM,
    S_BLANK,
    S_GATHER,
    S_CALC,
    S_WRITE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [1:0]     mode_q;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic [AW-1:0]  addr;
  logic [2:0]     g_idx, g_last, g_next;

  logic           s1_v, s1_zero;
  logic [AW-1:0]  s1_addr;
  logic           cap_v;
  logic [2:0]     cap_idx;
  logic [DW-1:0]  smp [6];
  logic [DW-1:0]  cur [6];

  logic copy_row, blank_row, last_c, last_r;
  logic ela_int, issue, accept;
  logic use_v, sel_cp, sel_v, sel_l;
  logic [DCW-1:0] d1, d2, d3;
  logic [DW-1:0]  calc_res;

  function automatic logic [CW-1:0] absd(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y
  );
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic logic [DW-1:0] avg(
    input logic [DW-1:0] x,
    input logic [DW-1:0] y
  );
    logic [DW-1:0] r;
    logic [CW:0]   s;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      s = {1'b0, x[k*CW +: CW]} + {1'b0, y[k*CW +: CW]};
      r[k*CW +: CW] = s[CW:1];
    end
    return r;
  endfunction

  assign copy_row  = !row[0] || mode_q == M_COPY;
  assign blank_row = !copy_row && mode_q == M_FIELD;
  assign last_c    = col == LAST_C;
  assign last_r    = row == LAST_R;
  assign ela_int   = mode_q == M_ELA && col != '0 && !last_c;

  // odd last row has no row below: single read of b, passed through
  assign g_last = last_r ? 3'd2 : ela_int ? 3'd5 : 3'd3;
  assign g_next = (!last_r && mode_q == M_ELA && col != PEN_C)
                ? 3'd0 : 3'd2;

  assign issue  = (state == S_ROW_SEL && (copy_row || blank_row))
               || state == S_STREAM || state == S_BLANK;
  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = state != S_IDLE && state != S_DONE;
  assign done   = state == S_DONE;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (start) nxt = S_ROW_SEL;
      S_ROW_SEL: nxt = copy_row  ? S_STREAM :
                       blank_row ? S_BLANK  : S_GATHER;
      S_STREAM,
      S_BLANK:   if (last_c) nxt = last_r ? S_DRAIN : S_ROW_SEL;
      S_GATHER:  if (g_idx == g_last) nxt = S_CALC;
      S_CALC:    nxt = S_WRITE;
      S_WRITE:   nxt = !last_c ? S_GATHER :
                       last_r  ? S_DONE   : S_ROW_SEL;
      S_DRAIN:   if (!s1_v) nxt = S_DONE;
      S_DONE:    nxt = start ? S_ROW_SEL : S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // neighbour order a, f, b, e, c', d
  always_comb begin
    rd_addr = '0;
    if (state == S_STREAM || (state == S_ROW_SEL && copy_row)) begin
      rd_addr = addr;
    end else if (state == S_GATHER) begin
      case (g_idx)
        3'd0:    rd_addr = addr - W_A - ONE_A;
        3'd1:    rd_addr = addr + W_A + ONE_A;
        3'd2:    rd_addr = addr - W_A;
        3'd3:    rd_addr = addr + W_A;
        3'd4:    rd_addr = addr - W_A + ONE_A;
        default: rd_addr = addr + W_A - ONE_A;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      cur[i] = (cap_v && cap_idx == 3'(i)) ? rd_data : smp[i];
    end
    d1 = '0;
    d2 = '0;
    d3 = '0;
    for (int k = 0; k < CH; k++) begin
      d1 = d1 + DCW'(absd(cur[0][k*CW +: CW], cur[1][k*CW +: CW]));
      d2 = d2 + DCW'(absd(cur[2][k*CW +: CW], cur[3][k*CW +: CW]));
      d3 = d3 + DCW'(absd(cur[4][k*CW +: CW], cur[5][k*CW +: CW]));
    end
  end

  // vertical wins ties; edges and LINE_AVG force vertical
  assign use_v  = !ela_int || (d2 <= d1 && d2 <= d3);
  assign sel_cp = last_r;
  assign sel_v  = !last_r && use_v;
  assign sel_l  = !last_r && !use_v && d1 <= d3;

  always_comb begin
    calc_res = avg(cur[4], cur[5]);
    unique case (1'b1)
      sel_cp:  calc_res = cur[2];
      sel_v:   calc_res = avg(cur[2], cur[3]);
      sel_l:   calc_res = avg(cur[0], cur[1]);
      default: ;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      row    <= '0;
      col    <= '0;
      addr   <= '0;
      g_idx  <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        row    <= '0;
        col    <= '0;
        addr   <= '0;
      end
      case (state)
        S_ROW_SEL: begin
          g_idx <= 3'd2;
          if (issue) begin
            col  <= CLW'(1);
            addr <= addr + ONE_A;
          end
        end
        S_STREAM, S_BLANK, S_WRITE: begin
          addr  <= addr + ONE_A;
          g_idx <= g_next;
          if (last_c) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CLW'(1);
          end
        end
        S_GATHER: g_idx <= g_idx + 3'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_zero <= 1'b0;
      s1_addr <= '0;
      cap_v   <= 1'b0;
      cap_idx <= '0;
      for (int i = 0; i < 6; i++) smp[i] <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      s1_v    <= issue;
      s1_zero <= blank_row;
      s1_addr <= addr;
      cap_v   <= state == S_GATHER;
      cap_idx <= g_idx;
      if (cap_v) smp[cap_idx] <= rd_data;
      wr_en <= s1_v || state == S_CALC;
      if (s1_v) begin
        wr_addr <= s1_addr;
        wr_data <= s1_zero ? '0 : rd_data;
      end else if (state == S_CALC) begin
        wr_addr <= addr;
        wr_data <= calc_res;
      end
    end
  end

endmodule
